branch_target_buffer: RTL and testbench



---
 rtl/bp_pkg.sv | 25 ++
 rtl/branch_target_buffer.sv | 113 +++++++++++
 tb/tb_branch_target_buffer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-prediction types: 2-bit direction counter and its update.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  function automatic ctr_t sat_update(
    input ctr_t c,
    input logic taken
  );
    ctr_t n;
    n = c;
    unique case (1'b1)
      taken && c != CTR_ST:   n = c + 2'd1;
      !taken && c != CTR_SNT: n = c - 2'd1;
      default:                n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged BTB with 2-bit direction counters, held in flops.
// Define BTB_STATS_EN to add saturating hit/update/mispredict counters.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int   ADDR_W     = 32,
  parameter int   INDEX_BITS = 4,
  parameter int   TAG_BITS   = ADDR_W - INDEX_BITS,
  parameter ctr_t INIT_CTR   = CTR_WT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] f_predict_addr,
  output logic              f_predict_valid,
  input  logic              d_is_branch,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic              x_valid,
  input  logic [ADDR_W-1:0] x_pc,
  input  logic              x_taken,
`ifdef BTB_STATS_EN
  input  logic [ADDR_W-1:0] x_target,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_mispredicts
`else
  input  logic [ADDR_W-1:0] x_target
`endif
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0]   tag_t;
  typedef logic [ADDR_W-1:0]     addr_t;

  logic [ENTRIES-1:0] valid_q;
  tag_t               tag_q [ENTRIES];
  addr_t              tgt_q [ENTRIES];
  ctr_t               ctr_q [ENTRIES];

  idx_t f_idx, d_idx, x_idx;
  tag_t f_tag, d_tag, x_tag;
  logic f_hit, d_hit, x_hit;
  logic train, alloc;

  assign f_idx = f_pc[INDEX_BITS-1:0];
  assign d_idx = d_pc[INDEX_BITS-1:0];
  assign x_idx = x_pc[INDEX_BITS-1:0];
  assign f_tag = f_pc[INDEX_BITS +: TAG_BITS];
  assign d_tag = d_pc[INDEX_BITS +: TAG_BITS];
  assign x_tag = x_pc[INDEX_BITS +: TAG_BITS];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign d_hit = valid_q[d_idx] && (tag_q[d_idx] == d_tag);
  assign x_hit = valid_q[x_idx] && (tag_q[x_idx] == x_tag);

  assign f_predict_valid = f_hit && ctr_q[f_idx][1];
  assign f_predict_addr  = f_hit ? tgt_q[f_idx] : '0;

  // A resolved branch owns its slot; a same-slot allocate is dropped.
  assign train = x_valid && x_hit;
  assign alloc = d_is_branch && !d_hit
              && !(train && (x_idx == d_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (train) begin
        ctr_q[x_idx] <= sat_update(ctr_q[x_idx], x_taken);
        if (x_taken)
          tgt_q[x_idx] <= x_target;
      end
      if (alloc) begin
        valid_q[d_idx] <= 1'b1;
        tag_q[d_idx]   <= d_tag;
        tgt_q[d_idx]   <= target_addr;
        ctr_q[d_idx]   <= INIT_CTR;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic mispredict;

  assign mispredict = (ctr_q[x_idx][1] != x_taken)
                   || (x_taken && (x_target != tgt_q[x_idx]));

  function automatic logic [31:0] sat_inc(
    input logic [31:0] c
  );
    return (c == '1) ? c : c + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits        <= '0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (f_predict_valid)
        stat_hits <= sat_inc(stat_hits);
      if (train)
        stat_updates <= sat_inc(stat_updates);
      if (train && mispredict)
        stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench: directed scenarios plus random traffic
// checked against an array-based reference model of the BTB.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic [31:0] f_predict_addr;
  logic        f_predict_valid;
  logic        d_is_branch;
  logic [31:0] d_pc;
  logic [31:0] target_addr;
  logic        x_valid;
  logic [31:0] x_pc;
  logic        x_taken;
  logic [31:0] x_target;
`ifdef BTB_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .f_pc            (f_pc),
    .f_predict_addr  (f_predict_addr),
    .f_predict_valid (f_predict_valid),
    .d_is_branch     (d_is_branch),
    .d_pc            (d_pc),
    .target_addr     (target_addr),
    .x_valid         (x_valid),
    .x_pc            (x_pc),
    .x_taken         (x_taken),
`ifdef BTB_STATS_EN
    .x_target        (x_target),
    .stat_hits       (stat_hits),
    .stat_updates    (stat_updates),
    .stat_mispredicts(stat_mispredicts)
`else
    .x_target        (x_target)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 16 slots, idx = pc mod 16, tag = pc / 16.
  bit          m_v   [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  logic [31:0] m_hits, m_upd, m_mis;

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = int'(pc % 16);
    return m_v[i] && (m_tag[i] == pc / 16);
  endfunction

  function automatic bit m_pv(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[int'(pc % 16)] >= 2);
  endfunction

  function automatic logic [31:0] m_pa(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[int'(pc % 16)] : 32'd0;
  endfunction

  function automatic logic [31:0] bump(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 1;
  endfunction

  task automatic model_edge();
    int  xi, di;
    bit  th, al;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_v[i] = 0;
      m_hits = 0;
      m_upd  = 0;
      m_mis  = 0;
      return;
    end
    xi = int'(x_pc % 16);
    di = int'(d_pc % 16);
    th = x_valid && m_hit(x_pc);
    al = d_is_branch && !m_hit(d_pc) && !(th && xi == di);
    if (m_pv(f_pc)) m_hits = bump(m_hits);
    if (th) begin
      m_upd = bump(m_upd);
      if (((m_ctr[xi] >= 2) != x_taken)
          || (x_taken && x_target != m_tgt[xi]))
        m_mis = bump(m_mis);
      if (x_taken) begin
        m_ctr[xi] = (m_ctr[xi] < 3) ? m_ctr[xi] + 1 : 3;
        m_tgt[xi] = x_target;
      end else begin
        m_ctr[xi] = (m_ctr[xi] > 0) ? m_ctr[xi] - 1 : 0;
      end
    end
    if (al) begin
      m_v[di]   = 1;
      m_tag[di] = d_pc / 16;
      m_tgt[di] = target_addr;
      m_ctr[di] = 2;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check("pv", {31'd0, f_predict_valid}, {31'd0, m_pv(f_pc)});
    check("pa", f_predict_addr, m_pa(f_pc));
`ifdef BTB_STATS_EN
    check("hits", stat_hits, m_hits);
    check("upd", stat_updates, m_upd);
    check("mis", stat_mispredicts, m_mis);
`endif
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drv(
    input logic        db,
    input logic [31:0] dp,
    input logic [31:0] ta,
    input logic        xv,
    input logic [31:0] xp,
    input logic        xt,
    input logic [31:0] xg
  );
    d_is_branch = db;
    d_pc        = dp;
    target_addr = ta;
    x_valid     = xv;
    x_pc        = xp;
    x_taken     = xt;
    x_target    = xg;
    f_pc        = dp;
    cycle();
    d_is_branch = 0;
    x_valid     = 0;
  endtask

  task automatic look(
    input logic [31:0] pc,
    input logic        ev,
    input logic [31:0] ea
  );
    f_pc = pc;
    #1;
    check("look_pv", {31'd0, f_predict_valid}, {31'd0, ev});
    check("look_pa", f_predict_addr, ea);
  endtask

  task automatic xres(input logic tk);
    drv(0, 0, 0, 1, 32'h21, tk, 32'h80);
  endtask

  logic [31:0] u0, m0;

  initial begin
    rst = 1; f_pc = 32'h10;
    d_is_branch = 0; d_pc = 0; target_addr = 0;
    x_valid = 0; x_pc = 0; x_taken = 0; x_target = 0;
    @(posedge clk);
    model_edge();
    #1;
    rst = 0;
    look(32'h10, 0, 0);

    drv(1, 32'h21, 32'h80, 0, 0, 0, 0);
    look(32'h21, 1, 32'h80);

    xres(0); look(32'h21, 0, 32'h80);
    xres(0); look(32'h21, 0, 32'h80);
    xres(0); look(32'h21, 0, 32'h80);
    xres(1); look(32'h21, 0, 32'h80);
    xres(1); look(32'h21, 1, 32'h80);
    xres(1); xres(1);
    look(32'h21, 1, 32'h80);
    xres(0); look(32'h21, 1, 32'h80);
    xres(0); look(32'h21, 0, 32'h80);

    drv(1, 32'h31, 32'h90, 0, 0, 0, 0);
    look(32'h21, 0, 0);
    look(32'h31, 1, 32'h90);

    drv(1, 32'h21, 32'h80, 0, 0, 0, 0);
    look(32'h21, 1, 32'h80);
    drv(1, 32'h41, 32'h55, 1, 32'h21, 1, 32'h80);
    look(32'h21, 1, 32'h80);
    look(32'h41, 0, 0);
    xres(0);
    look(32'h21, 1, 32'h80);

`ifdef BTB_STATS_EN
    u0 = stat_updates;
    m0 = stat_mispredicts;
`else
    u0 = 0;
    m0 = 0;
`endif
    drv(0, 0, 0, 1, 32'h21, 1, 32'hA0);
    look(32'h21, 1, 32'hA0);
`ifdef BTB_STATS_EN
    check("upd_d", stat_updates - u0, 1);
    check("mis_d", stat_mispredicts - m0, 1);
`endif

    rst = 1;
    drv(1, 32'h22, 32'h70, 1, 32'h21, 1, 32'hB0);
    rst = 0;
    look(32'h21, 0, 0);
    look(32'h22, 0, 0);

    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom_range(0, 149) == 0);
      d_is_branch = ($urandom_range(0, 2) == 0);
      x_valid     = ($urandom_range(0, 1) == 0);
      x_pc        = $urandom_range(0, 63);
      x_taken     = $urandom_range(0, 1);
      x_target    = $urandom_range(0, 3) * 32'h100;
      if ($urandom_range(0, 3) == 0)
        d_pc = ($urandom_range(0, 3) * 16) + (x_pc % 16);
      else
        d_pc = $urandom_range(0, 63);
      target_addr = $urandom;
      f_pc        = $urandom_range(0, 63);
      cycle();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
